// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, immediate
// formats, ALU operations, controller states and datapath mux selects.
package core_ctrl_pkg;

    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned IMM_SRC_W = 3;
    localparam int unsigned ALU_CTL_W = 4;
    localparam int unsigned SEL_W     = 2;

    // Supported major opcodes
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

    // Immediate extender format select
    localparam logic [IMM_SRC_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_SRC_W-1:0] IMM_U = 3'b001;
    localparam logic [IMM_SRC_W-1:0] IMM_S = 3'b010;
    localparam logic [IMM_SRC_W-1:0] IMM_B = 3'b011;
    localparam logic [IMM_SRC_W-1:0] IMM_J = 3'b100;

    // Result bus select
    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    // ALU operand A select
    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;
    localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [ALU_CTL_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    // Operation class handed from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRWB   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_e;

    // Immediate format implied by a major opcode; I-format for anything without one
    function automatic logic [IMM_SRC_W-1:0] imm_src_for(input logic [OPCODE_W-1:0] op);
        logic [IMM_SRC_W-1:0] imm;
        case (op)
            OP_STORE:         imm = IMM_S;
            OP_BRANCH:        imm = IMM_B;
            OP_JAL:           imm = IMM_J;
            OP_LUI, OP_AUIPC: imm = IMM_U;
            default:          imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Decode inputs and datapath control outputs between controller and datapath.
interface multicycle_control_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       halted;

    // Controller side
    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
        output result_src, alu_src_a, alu_src_b, imm_src, alu_control, halted
    );

    // Datapath / memory side
    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, imm_src, alu_control, halted
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU operation decode from FSM op class plus funct fields.
module alu_decoder
    import core_ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op5,
    output alu_ctrl_e  alu_control
);

    // op5 distinguishes R-type (SUB allowed) from I-ALU (ADDI only)
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core.
// Optional build macro INSTRET_COUNTER_EN adds a retired-instruction counter.
module multicycle_control
    import core_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
`ifdef INSTRET_COUNTER_EN
    ,
    output logic [31:0]          instret
`endif
);

    state_e     state_q, state_d;

    logic       mem_req_c;
    logic       adr_src_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       reg_write_c;
    logic       halted_c;
    logic [1:0] result_src_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [2:0] imm_src_c;
    alu_op_e    alu_op_c;
    alu_ctrl_e  alu_ctrl_c;
    logic       branch_taken_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_IALU:           state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRWB;
            S_JALRWB:   state_d = S_FETCH;
            S_LUI:      state_d = S_ALUWB;
            S_AUIPC:    state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // beq takes on zero, bne on non-zero; other funct3 never redirect
    always_comb begin
        branch_taken_c = ((bus.funct3 == 3'b000) &&  bus.zero) ||
                         ((bus.funct3 == 3'b001) && !bus.zero);
    end

    // Per-state datapath controls (FETCH strobes follow mem_ready)
    always_comb begin
        mem_req_c    = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        halted_c     = 1'b0;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RD2;
        imm_src_c    = IMM_I;
        alu_op_c     = ALU_OP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                adr_src_c    = 1'b0;
                alu_src_a_c  = SRCA_PC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                ir_write_c   = bus.mem_ready;
                pc_write_c   = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = imm_src_for(bus.opcode);
            end
            S_MEMADR: begin
                alu_src_a_c = SRCA_RD1;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = bus.opcode[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
            end
            S_MEMWB: begin
                result_src_c = RES_MEMDATA;
                reg_write_c  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_c = SRCA_RD1;
                alu_src_b_c = SRCB_RD2;
                alu_op_c    = ALU_OP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a_c = SRCA_RD1;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = IMM_I;
                alu_op_c    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c  = SRCA_RD1;
                alu_src_b_c  = SRCB_RD2;
                alu_op_c     = ALU_OP_SUB;
                result_src_c = RES_ALUOUT;
                pc_write_c   = branch_taken_c;
            end
            S_JAL: begin
                alu_src_a_c  = SRCA_OLDPC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALUOUT;
                pc_write_c   = 1'b1;
            end
            S_JALR: begin
                alu_src_a_c  = SRCA_RD1;
                alu_src_b_c  = SRCB_IMM;
                imm_src_c    = IMM_I;
                result_src_c = RES_ALURESULT;
                pc_write_c   = 1'b1;
            end
            S_JALRWB: begin
                alu_src_a_c  = SRCA_OLDPC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                reg_write_c  = 1'b1;
            end
            S_LUI: begin
                alu_src_a_c = SRCA_ZERO;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = IMM_U;
            end
            S_AUIPC: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                imm_src_c   = IMM_U;
            end
            S_ILLEGAL: begin
                halted_c = 1'b1;
            end
            default: begin
                halted_c = 1'b0;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op_c),
        .funct3      (bus.funct3),
        .funct7_5    (bus.funct7_5),
        .op5         (bus.opcode[5]),
        .alu_control (alu_ctrl_c)
    );

    // Strobes are forced low while reset is held so nothing leaks out of FETCH
    assign bus.mem_req     = rst_n & mem_req_c;
    assign bus.mem_write   = rst_n & mem_write_c;
    assign bus.ir_write    = rst_n & ir_write_c;
    assign bus.pc_write    = rst_n & pc_write_c;
    assign bus.reg_write   = rst_n & reg_write_c;
    assign bus.halted      = rst_n & halted_c;
    assign bus.adr_src     = adr_src_c;
    assign bus.result_src  = result_src_c;
    assign bus.alu_src_a   = alu_src_a_c;
    assign bus.alu_src_b   = alu_src_b_c;
    assign bus.imm_src     = imm_src_c;
    assign bus.alu_control = alu_ctrl_c;

`ifdef INSTRET_COUNTER_EN
    logic [31:0] instret_q, instret_d;

    // Count on every transition back into FETCH; ILLEGAL never returns there
    always_comb begin
        instret_d = instret_q;
        if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // Retired-instruction counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   exp_instret;
    logic [5:0] strb;

    multicycle_control_if bus_if ();

`ifdef INSTRET_COUNTER_EN
    logic [31:0] instret;
`endif

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
`ifdef INSTRET_COUNTER_EN
        ,
        .instret (instret)
`endif
    );

    // {mem_req, mem_write, ir_write, pc_write, reg_write, halted}
    assign strb = {bus_if.mem_req, bus_if.mem_write, bus_if.ir_write,
                   bus_if.pc_write, bus_if.reg_write, bus_if.halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus_if.opcode   = op;
        bus_if.funct3   = f3;
        bus_if.funct7_5 = f7;
    endtask

    task automatic fetch_step();
        chk("fetch_strb", 32'(strb), 'b101100);
        chk("fetch_adr",  32'(bus_if.adr_src), 0);
        chk("fetch_a",    32'(bus_if.alu_src_a), 0);
        chk("fetch_b",    32'(bus_if.alu_src_b), 2);
        chk("fetch_res",  32'(bus_if.result_src), 2);
        chk("fetch_alu",  32'(bus_if.alu_control), 0);
        tick();
    endtask

    task automatic decode_step(input logic [2:0] imm, input bit use_imm);
        chk("dec_strb", 32'(strb), 0);
        chk("dec_a",    32'(bus_if.alu_src_a), 1);
        chk("dec_b",    32'(bus_if.alu_src_b), 1);
        chk("dec_alu",  32'(bus_if.alu_control), 0);
        if (use_imm) chk("dec_imm", 32'(bus_if.imm_src), 32'(imm));
        tick();
    endtask

    task automatic aluwb_step();
        chk("aluwb_strb", 32'(strb), 'b000010);
        chk("aluwb_res",  32'(bus_if.result_src), 0);
        tick();
        exp_instret++;
    endtask

    task automatic exec_r(input logic [2:0] f3, input logic f7, input logic [3:0] alu);
        set_instr(7'b0110011, f3, f7);
        fetch_step();
        decode_step(3'b000, 1'b0);
        chk("execr_strb", 32'(strb), 0);
        chk("execr_a",    32'(bus_if.alu_src_a), 2);
        chk("execr_b",    32'(bus_if.alu_src_b), 0);
        chk("execr_alu",  32'(bus_if.alu_control), 32'(alu));
        tick();
        aluwb_step();
    endtask

    task automatic exec_i(input logic [2:0] f3, input logic f7, input logic [3:0] alu);
        set_instr(7'b0010011, f3, f7);
        fetch_step();
        decode_step(3'b000, 1'b1);
        chk("execi_strb", 32'(strb), 0);
        chk("execi_a",    32'(bus_if.alu_src_a), 2);
        chk("execi_b",    32'(bus_if.alu_src_b), 1);
        chk("execi_imm",  32'(bus_if.imm_src), 0);
        chk("execi_alu",  32'(bus_if.alu_control), 32'(alu));
        tick();
        aluwb_step();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        exp_instret = 0;
        rst_n            = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.zero      = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_strb", 32'(strb), 0);
`ifdef INSTRET_COUNTER_EN
        chk("reset_instret", instret, 0);
`endif
        rst_n = 1'b1;
        #1;

        // R-type / I-ALU decode
        exec_r(3'b000, 1'b0, 4'b0000);   // add
        exec_r(3'b000, 1'b1, 4'b0001);   // sub
        exec_r(3'b111, 1'b0, 4'b0010);   // and
        exec_i(3'b101, 1'b1, 4'b1000);   // srai
        exec_i(3'b000, 1'b1, 4'b0000);   // addi never becomes sub

        // lw with three wait cycles in MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_step();
        decode_step(3'b000, 1'b1);
        chk("lw_memadr_strb", 32'(strb), 0);
        chk("lw_memadr_a",    32'(bus_if.alu_src_a), 2);
        chk("lw_memadr_b",    32'(bus_if.alu_src_b), 1);
        chk("lw_memadr_imm",  32'(bus_if.imm_src), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_if.mem_ready = (i == 3);
            #1;
            chk("lw_memread_strb", 32'(strb), 'b100000);
            chk("lw_memread_adr",  32'(bus_if.adr_src), 1);
            tick();
        end
        chk("lw_memwb_strb", 32'(strb), 'b000010);
        chk("lw_memwb_res",  32'(bus_if.result_src), 1);
        tick();
        exp_instret++;

        // sw with one wait cycle in MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_step();
        decode_step(3'b010, 1'b1);
        chk("sw_memadr_imm", 32'(bus_if.imm_src), 2);
        tick();
        bus_if.mem_ready = 1'b0;
        #1;
        chk("sw_memwrite_strb", 32'(strb), 'b110000);
        chk("sw_memwrite_adr",  32'(bus_if.adr_src), 1);
        tick();
        bus_if.mem_ready = 1'b1;
        #1;
        chk("sw_memwrite_strb2", 32'(strb), 'b110000);
        tick();
        exp_instret++;

        // beq taken, bne not taken, both with zero=1
        bus_if.zero = 1'b1;
        set_instr(7'b1100011, 3'b000, 1'b0);
        fetch_step();
        decode_step(3'b011, 1'b1);
        chk("beq_strb", 32'(strb), 'b000100);
        chk("beq_alu",  32'(bus_if.alu_control), 1);
        chk("beq_a",    32'(bus_if.alu_src_a), 2);
        chk("beq_b",    32'(bus_if.alu_src_b), 0);
        chk("beq_res",  32'(bus_if.result_src), 0);
        tick();
        exp_instret++;
        set_instr(7'b1100011, 3'b001, 1'b0);
        fetch_step();
        decode_step(3'b011, 1'b1);
        chk("bne_strb", 32'(strb), 0);
        chk("bne_alu",  32'(bus_if.alu_control), 1);
        tick();
        exp_instret++;
        bus_if.zero = 1'b0;

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        fetch_step();
        decode_step(3'b100, 1'b1);
        chk("jal_strb", 32'(strb), 'b000100);
        chk("jal_a",    32'(bus_if.alu_src_a), 1);
        chk("jal_b",    32'(bus_if.alu_src_b), 2);
        chk("jal_res",  32'(bus_if.result_src), 0);
        tick();
        aluwb_step();

        // jalr
        set_instr(7'b1100111, 3'b000, 1'b0);
        fetch_step();
        decode_step(3'b000, 1'b1);
        chk("jalr_strb", 32'(strb), 'b000100);
        chk("jalr_res",  32'(bus_if.result_src), 2);
        chk("jalr_imm",  32'(bus_if.imm_src), 0);
        chk("jalr_a",    32'(bus_if.alu_src_a), 2);
        chk("jalr_b",    32'(bus_if.alu_src_b), 1);
        tick();
        chk("jalrwb_strb", 32'(strb), 'b000010);
        chk("jalrwb_a",    32'(bus_if.alu_src_a), 1);
        chk("jalrwb_b",    32'(bus_if.alu_src_b), 2);
        chk("jalrwb_res",  32'(bus_if.result_src), 2);
        tick();
        exp_instret++;

        // lui / auipc
        set_instr(7'b0110111, 3'b000, 1'b0);
        fetch_step();
        decode_step(3'b001, 1'b1);
        chk("lui_strb", 32'(strb), 0);
        chk("lui_a",    32'(bus_if.alu_src_a), 3);
        chk("lui_b",    32'(bus_if.alu_src_b), 1);
        chk("lui_imm",  32'(bus_if.imm_src), 1);
        tick();
        aluwb_step();
        set_instr(7'b0010111, 3'b000, 1'b0);
        fetch_step();
        decode_step(3'b001, 1'b1);
        chk("auipc_a",   32'(bus_if.alu_src_a), 1);
        chk("auipc_b",   32'(bus_if.alu_src_b), 1);
        chk("auipc_imm", 32'(bus_if.imm_src), 1);
        tick();
        aluwb_step();

        // FETCH stalls while memory is not ready
        bus_if.mem_ready = 1'b0;
        #1;
        chk("fetch_stall_strb", 32'(strb), 'b100000);
        tick();
        chk("fetch_stall_strb2", 32'(strb), 'b100000);
        bus_if.mem_ready = 1'b1;
        #1;
`ifdef INSTRET_COUNTER_EN
        chk("instret_count", instret, 32'(exp_instret));
`endif

        // Illegal opcode traps until reset
        set_instr(7'b1111111, 3'b000, 1'b0);
        fetch_step();
        decode_step(3'b000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("illegal_strb", 32'(strb), 'b000001);
            tick();
        end
`ifdef INSTRET_COUNTER_EN
        chk("illegal_instret", instret, 32'(exp_instret));
`endif
        rst_n = 1'b0;
        #1;
        chk("illegal_reset_strb", 32'(strb), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_illegal_fetch", 32'(strb), 'b101100);

        // Reset dropped in the middle of a store
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_step();
        decode_step(3'b010, 1'b1);
        tick();
        bus_if.mem_ready = 1'b0;
        #1;
        chk("abort_memwrite_strb", 32'(strb), 'b110000);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_write", 32'(bus_if.mem_write), 0);
        chk("abort_mem_req",   32'(bus_if.mem_req), 0);
        tick();
        bus_if.mem_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("abort_fetch_strb", 32'(strb), 'b101100);
`ifdef INSTRET_COUNTER_EN
        chk("abort_instret", instret, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
